// File: rtl/clk_rst_pkg.sv
// Shared definitions for the clock/reset manager slice: controller state
// encoding, the divider phase that marks a safe gate-change point, and the
// width of the optional enabled-period counter.
package clk_rst_pkg;

  typedef enum logic [2:0] {
    RST_WAIT = 3'd0,
    OFF      = 3'd1,
    ARM_ON   = 3'd2,
    ON       = 3'd3,
    ARM_OFF  = 3'd4
  } ctrl_state_t;

  // Phase word {div8, div4, div2} sampled just before div8 falls low.
  localparam logic [2:0] PHASE_BOUNDARY = 3'b100;

  localparam int CYC_CNT_W = 32;

  // True when the sampled phase word is the last cycle of a div8 high phase.
  function automatic logic is_boundary(input logic [2:0] ph);
    return ph == PHASE_BOUNDARY;
  endfunction

endpackage

// File: rtl/clk_en_ctrl_if.sv
// Processor-side run/halt handshake of the clock-enable controller.
// The processor (master) requests run and pulses halt; the controller
// (slave) reports whether the clock is running and whether it is halted.
interface clk_en_ctrl_if;

  logic run_req;
  logic halt_req;
  logic run_ack;
  logic halted;

  modport master (
    output run_req,
    output halt_req,
    input  run_ack,
    input  halted
  );

  modport slave (
    input  run_req,
    input  halt_req,
    output run_ack,
    output halted
  );

endinterface

// File: rtl/clk_en_ctrl.sv
// Processor clock-enable controller. Drives the gate enable of the clock/reset
// manager, changing it only on the divider phase boundary so the gated div8
// clock never glitches. Sequences against the synchronized reset, honours
// halt pulses and enforces a minimum off time between stop and restart.
// Optional feature: define CLK_EN_CTRL_CYCCNT_EN to add the cyc_cnt port, a
// free-running count of completed (enabled) div8 periods.
module clk_en_ctrl
  import clk_rst_pkg::*;
#(
  parameter int unsigned MIN_OFF = 2
) (
  input  logic          clk_in,
  input  logic          rst_async,
  input  logic          rst_sync_n,
  input  logic          clk_div2,
  input  logic          clk_div4,
  input  logic          clk_div8,
  clk_en_ctrl_if.slave  proc,
  output logic          en_clk_div8
`ifdef CLK_EN_CTRL_CYCCNT_EN
  ,
  output logic [CYC_CNT_W-1:0] cyc_cnt
`endif
);

  localparam logic [3:0] MIN_OFF_L = 4'(MIN_OFF);

  ctrl_state_t state_reg;
  logic        en_reg;
  logic        run_ack_reg;
  logic        halted_reg;
  logic [3:0]  cool_reg;
  logic        boundary;

  // The divider counts down; the boundary is the cycle before div8 falls.
  assign boundary = is_boundary({clk_div8, clk_div4, clk_div2});

  // Control FSM; enable, ack, halt flag and cool-down counter are all registered here.
  always_ff @(posedge clk_in or posedge rst_async) begin
    if (rst_async) begin
      state_reg   <= RST_WAIT;
      en_reg      <= 1'b0;
      run_ack_reg <= 1'b0;
      halted_reg  <= 1'b0;
      cool_reg    <= 4'd0;
    end else if (!rst_sync_n) begin
      // Processor is held in reset, so dropping the enable off-boundary is safe.
      // The halt flag survives so a halted processor does not restart by itself.
      state_reg   <= RST_WAIT;
      en_reg      <= 1'b0;
      run_ack_reg <= 1'b0;
      cool_reg    <= 4'd0;
    end else begin
      case (state_reg)
        RST_WAIT: begin
          en_reg      <= 1'b0;
          run_ack_reg <= 1'b0;
          state_reg   <= OFF;
        end
        OFF: begin
          if (!proc.run_req) begin
            halted_reg <= 1'b0;
          end
          if (boundary && (cool_reg != 4'd0)) begin
            cool_reg <= cool_reg - 4'd1;
          end
          if (proc.run_req && !halted_reg && (cool_reg == 4'd0)) begin
            state_reg <= ARM_ON;
          end
        end
        ARM_ON: begin
          // A withdrawn request wins over a coincident boundary: never enable.
          if (!proc.run_req) begin
            state_reg <= OFF;
          end else if (boundary) begin
            en_reg      <= 1'b1;
            run_ack_reg <= 1'b1;
            state_reg   <= ON;
          end
        end
        ON: begin
          if (proc.halt_req || !proc.run_req) begin
            run_ack_reg <= 1'b0;
            state_reg   <= ARM_OFF;
            if (proc.halt_req) begin
              halted_reg <= 1'b1;
            end
          end
        end
        ARM_OFF: begin
          if (proc.halt_req) begin
            halted_reg <= 1'b1;
          end
          if (boundary) begin
            en_reg    <= 1'b0;
            cool_reg  <= MIN_OFF_L;
            state_reg <= OFF;
          end
        end
        default: begin
          en_reg      <= 1'b0;
          run_ack_reg <= 1'b0;
          state_reg   <= RST_WAIT;
        end
      endcase
    end
  end

  assign en_clk_div8  = en_reg;
  assign proc.run_ack = run_ack_reg;
  assign proc.halted  = halted_reg;

`ifdef CLK_EN_CTRL_CYCCNT_EN
  logic [CYC_CNT_W-1:0] cyc_cnt_reg;

  // Count each div8 period that completed with the gate open; wraps naturally.
  always_ff @(posedge clk_in or posedge rst_async) begin
    if (rst_async) begin
      cyc_cnt_reg <= '0;
    end else if (boundary && en_reg) begin
      cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
    end
  end

  assign cyc_cnt = cyc_cnt_reg;
`endif

endmodule

// File: doc/clk_en_ctrl.md
# clk_en_ctrl

Processor clock-enable controller; drives the `en_clk_div8` gate input of the clock/reset manager.
- Turns the processor clock on and off glitch-free, changing the enable only at a fixed divider phase boundary.
- Sequences the enable against the synchronized reset, honours processor halt requests, and enforces a minimum off time between stop and restart.
- Sits beside the clock/reset manager in the `clk_in` domain.

## Interface
- `MIN_OFF`, default 2: minimum number of div8 periods the enable stays low after a stop. Range 0..15.
- `clk_in` in 1: system clock, the undivided clock of the manager.
- `rst_async` in 1: asynchronous, active-high reset.
- `rst_sync_n` in 1: synchronized reset from the manager, active-low.
- `clk_div2`, `clk_div4`, `clk_div8` in 1 each: divider counter bits from the manager, registered in `clk_in`.
- `run_req` in 1: level request to run the processor clock.
- `halt_req` in 1: single-cycle halt pulse from the processor.
- `en_clk_div8` out 1: gate enable to the manager.
- `run_ack` out 1: high while the clock is running.
- `halted` out 1: sticky halt indication.
- `cyc_cnt` out 32: count of enabled div8 periods. Present only with the macro.

## Operation
- Phase word: `ph = {clk_div8, clk_div4, clk_div2}`. The divider counts down.
- `boundary = (ph == 3'b100)`. At the edge following this value, div8 falls to 0 and stays 0 for 4 cycles.
- `en_clk_div8` changes only on a boundary edge. The single exception is the reset path.
- FSM states: `RST_WAIT`, `OFF`, `ARM_ON`, `ON`, `ARM_OFF`. Transitions:
  - `RST_WAIT`: hold `en=0`. Go to `OFF` when `rst_sync_n=1`.
  - `OFF`: go to `ARM_ON` when `run_req && !halted && cool==0`. If `run_req=0`, clear `halted`.
  - `ARM_ON`: on boundary, set `en<=1` and go to `ON`. If `run_req` falls before the boundary, return to `OFF` with no enable.
  - `ON`: go to `ARM_OFF` if `!run_req` or `halt_req`.
  - `ARM_OFF`: on boundary, set `en<=0`, load `cool<=MIN_OFF`, and go to `OFF`.
- `halt_req` in `ON` or `ARM_OFF` sets `halted`. It stays set until `run_req=0` is seen in `OFF`.
- `cool` is a 4-bit counter. It decrements on each boundary while in `OFF` and `cool>0`, and saturates at 0.
- `run_ack` is registered and equals (state==`ON`).
- `rst_sync_n=0` in any state forces `RST_WAIT`, `en=0`, `run_ack=0`, `cool=0` at the next edge. `halted` is preserved. The processor is held in reset, so a truncated pulse is harmless.
- Simultaneous events:
  - `halt_req` together with a `run_req` fall: treat as a halt.
  - `rst_sync_n=0` overrides all other inputs.

## Timing
- Reset values (`rst_async=1`): state `RST_WAIT`, `en_clk_div8=0`, `run_ack=0`, `halted=0`, `cool=0`, `cyc_cnt=0`.
- Start latency: `run_req` rising seen in `OFF` at edge t gives `ARM_ON` at t+1. `en` rises at the first edge after t+1 where boundary is sampled, i.e. 1–8 cycles later.
- Gated clock start: the first processor clock pulse after enable is preceded by a full 4-cycle low phase. Every pulse is 4 cycles high.
- Stop latency: 1–8 cycles after entering `ARM_OFF`. The last high phase is always complete.
- Restart after stop requires `MIN_OFF` boundaries in `OFF`, plus the arming latency.
- `run_ack` falls 1 cycle after the stop condition, before `en` falls.

## Configuration
- `CLK_EN_CTRL_CYCCNT_EN` defined:
  - Adds the `cyc_cnt` port and a 32-bit counter.
  - Increments on every boundary edge where `en_clk_div8=1`, i.e. each completed processor clock.
  - Wraps from `0xFFFFFFFF` to 0. Cleared only by `rst_async`.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package `clk_rst_pkg`:
  - FSM state enum.
  - `PHASE_BOUNDARY = 3'b100`.
  - `CYC_CNT_W = 32`.
- No sub-module. Boundary detect, cool counter and cycle counter are inline.

## Test plan
- Assert `rst_async` → all outputs 0. Release with `rst_sync_n=0` → stays in `RST_WAIT`, `en=0`. Raise `rst_sync_n` → `OFF`.
- `run_req=1` at ph=3'b111 → `en` rises 4 cycles later, at the edge after ph=3'b100. Gated clock: 4 low cycles, then 4 high. `run_ack=1` with `en`.
- `MIN_OFF=2`: drop `run_req` in `ON` → `en` falls at the next boundary. Reassert at once → `en` rises only after 2 boundaries in `OFF` plus arming (≈17–24 cycles).
- `halt_req` pulse in `ON` with `run_req` held → `en` falls at the boundary, `halted=1`, and no re-enable. Drop `run_req` → `halted=0`. Raise `run_req` → restarts.
- `rst_sync_n` to 0 mid-`ON` at ph=3'b110 → `en=0` and `run_ack=0` next cycle, state `RST_WAIT`.
- Macro on:
  - 10 full enabled periods → `cyc_cnt=10`.
  - Force `cyc_cnt=0xFFFFFFFF`, then one more period → 0.
